afe_tdc_spi: RTL

Parametrised successor to the AFE CPLD control logic. It measures, per channel, the delay from the injection trigger to the comparator rising edge and the comparator time-over-threshold, both in CLK cycles. Results, status and a GPIO register are accessed through an SPI slave that is oversampled in the CLK domain. It sits between the board SPI master and the analog front-end: injection pulser, comparators, GPIO and LED.

---
 rtl/afe_tdc_spi_pkg.sv | 15 +
 rtl/afe_tdc_spi_if.sv | 9 +
 rtl/afe_tdc_spi_ch.sv | 42 ++++
 rtl/afe_tdc_spi.sv | 102 ++++++++++
 4 files changed

// File: rtl/afe_tdc_spi_pkg.sv
// afe_pkg: register map, CTRL bit positions and channel state encoding
package afe_pkg;
  localparam logic [6:0] ADDR_CTRL = 7'h00;
  localparam logic [6:0] ADDR_GPIO = 7'h01;
  localparam logic [6:0] ADDR_STATUS = 7'h02;
  localparam logic [6:0] ADDR_RES_BASE = 7'h10;
  localparam int CTRL_ARM = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_HIT_EN = 2;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT_INJ = 3'd1;
  localparam logic [2:0] DLY = 3'd2;
  localparam logic [2:0] TOT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
endpackage

// File: rtl/afe_tdc_spi_if.sv
// afe_tdc_spi_if: board SPI bus between master and the AFE slave
interface afe_tdc_spi_if;
  logic SCLK;
  logic CS_B;
  logic MOSI;
  logic MISO;
  modport master(output SCLK, CS_B, MOSI, input MISO);
  modport slave(input SCLK, CS_B, MOSI, output MISO);
endinterface

// File: rtl/afe_tdc_spi_ch.sv
// afe_ch_tdc: one channel's injection-to-hit delay and time-over-threshold counters
module afe_ch_tdc import afe_pkg::*; #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             clr,
  input  logic             inj_rise,
  input  logic             inj_fall,
  input  logic             comp_rise,
  input  logic             comp_fall,
  output logic             done,
  output logic [CNT_W-1:0] dly,
  output logic [CNT_W-1:0] tot
);
  logic [2:0] st;
  assign done = st == DONE;
  // arm/clear outrank any same-cycle measurement event
  always_ff @(posedge clk)
    if (rst || clr) begin
      st <= IDLE;
      dly <= '0;
      tot <= '0;
    end else if (arm) begin
      st <= WAIT_INJ;
      dly <= '0;
      tot <= '0;
    end else
      case (st)
        WAIT_INJ: if (inj_rise) st <= comp_rise ? TOT : DLY;
        DLY: begin
          dly <= (inj_fall && !comp_rise) ? '1 : (&dly ? dly : dly + CNT_W'(1));
          st <= comp_rise ? TOT : (inj_fall ? DONE : DLY);
        end
        TOT: begin
          tot <= &tot ? tot : tot + CNT_W'(1);
          if (comp_fall) st <= DONE;
        end
        default: ;
      endcase
endmodule

// File: rtl/afe_tdc_spi.sv
// afe_tdc_spi: input synchronisers, oversampled SPI slave, register file and per-channel TDCs
module afe_tdc_spi import afe_pkg::*; #(
  parameter int N_CH = 4,
  parameter int CNT_W = 8
) (
  input  logic            CLK,
  input  logic            RST,
  afe_tdc_spi_if.slave    spi,
  input  logic            INJ_IN,
  input  logic [N_CH-1:0] COMP,
  output logic            HIT,
  output logic [7:0]      GPIO,
  output logic            LED
);
  localparam int W = N_CH + 3;
  logic [W-1:0] s1, s2, s3, rise, fall;
  logic [1:0] mosi_s;
  logic [4:0] cnt;
  logic [15:0] rx;
  logic [7:0] tx, rd;
  logic [6:0] rd_addr;
  logic miso_q, hit_en, arm, clr, commit;
  logic [N_CH-1:0] done;
  logic [N_CH-1:0][CNT_W-1:0] dly, tot;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign rd_addr = {rx[5:0], mosi_s[1]};
  assign commit = rise[1] && cnt == 5'd16 && !rx[15];
  assign spi.MISO = miso_q;
  assign LED = |done;
  // bit 0 SCLK, bit 1 CS_B (resets high = deselected), bit 2 INJ, then COMP
  always_ff @(posedge CLK)
    if (RST) begin
      s1 <= W'(2);
      s2 <= W'(2);
      s3 <= W'(2);
      mosi_s <= '0;
    end else begin
      s1 <= {COMP, INJ_IN, spi.CS_B, spi.SCLK};
      s2 <= s1;
      s3 <= s2;
      mosi_s <= {mosi_s[0], spi.MOSI};
    end
  always_ff @(posedge CLK)
    if (RST) begin
      GPIO <= '0;
      hit_en <= 1'b0;
      arm <= 1'b0;
      clr <= 1'b0;
      HIT <= 1'b0;
    end else begin
      arm <= commit && rx[14:8] == ADDR_CTRL && rx[CTRL_ARM];
      clr <= commit && rx[14:8] == ADDR_CTRL && rx[CTRL_CLR];
      if (commit && rx[14:8] == ADDR_CTRL) hit_en <= rx[CTRL_HIT_EN];
      if (commit && rx[14:8] == ADDR_GPIO) GPIO <= rx[7:0];
      HIT <= hit_en && |s3[W-1:3];
    end
  always_comb begin
    rd = '0;
    if (rd_addr == ADDR_CTRL) rd[CTRL_HIT_EN] = hit_en;
    if (rd_addr == ADDR_GPIO) rd = GPIO;
    if (rd_addr == ADDR_STATUS) rd = 8'(done);
    for (int i = 0; i < N_CH; i++) begin
      if (rd_addr == 7'(ADDR_RES_BASE + 2 * i)) rd = 8'(dly[i]);
      if (rd_addr == 7'(ADDR_RES_BASE + 2 * i + 1)) rd = 8'(tot[i]);
    end
  end
  // read data is snapshotted into tx on the 8th SCLK rise and shifted out on falls
  always_ff @(posedge CLK)
    if (RST) begin
      cnt <= '0;
      rx <= '0;
      tx <= '0;
      miso_q <= 1'b1;
    end else if (s2[1]) begin
      cnt <= '0;
      miso_q <= 1'b1;
    end else begin
      if (rise[0]) begin
        rx <= {rx[14:0], mosi_s[1]};
        cnt <= cnt + 5'(cnt != 5'd31);
        if (cnt == 5'd7) tx <= rx[6] ? rd : 8'h00;
      end
      if (fall[0] && cnt >= 5'd8) tx <= {tx[6:0], 1'b0};
      miso_q <= fall[0] ? (cnt >= 5'd8 && tx[7]) : (fall[1] ? 1'b0 : miso_q);
    end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    afe_ch_tdc #(.CNT_W(CNT_W)) u_ch (
      .clk(CLK),
      .rst(RST),
      .arm(arm),
      .clr(clr),
      .inj_rise(rise[2]),
      .inj_fall(fall[2]),
      .comp_rise(rise[3+g]),
      .comp_fall(fall[3+g]),
      .done(done[g]),
      .dly(dly[g]),
      .tot(tot[g])
    );
  end
endmodule
